// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared event kinds, button state encoding and timing helper
package btn_pkg;

    localparam logic [1:0] EVT_PRESS  = 2'b00;
    localparam logic [1:0] EVT_LONG   = 2'b01;
    localparam logic [1:0] EVT_REPEAT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HELD = 2'b01,
        ST_LONG = 2'b10
    } btn_state_t;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_event_arbiter_if.sv
// rtl/btn_event_arbiter_if.sv - shared event channel between the arbiter and its consumer
interface btn_event_arbiter_if #(
    parameter int N_BTN = 4
);
    localparam int BW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    logic          evt_valid;
    logic          evt_ready;
    logic [BW-1:0] evt_btn;
    logic [1:0]    evt_kind;
    logic          drop_pulse;

    modport master (
        output evt_valid,
        output evt_btn,
        output evt_kind,
        output drop_pulse,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_btn,
        input  evt_kind,
        input  drop_pulse,
        output evt_ready
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant over N requesters; pointer moves only on a taken grant
module rr_arbiter #(
    parameter int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic          found;
    logic [IW-1:0] idx;
    int            cand;

    // Search starts at ptr and wraps; the first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            idx = IW'(cand);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - per-button PRESS/LONG/REPEAT classifier sharing one event channel
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN     = 4,
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BTN-1:0]     press_pulse,
    input  logic [N_BTN-1:0]     btn_stable,
    btn_event_arbiter_if.master  evt
);

    localparam int unsigned LONG_CNT = ms_to_cycles(CLK_HZ, LONG_MS);
    localparam int unsigned REP_CNT  = ms_to_cycles(CLK_HZ, REPEAT_MS);
    localparam int HW = $clog2(LONG_CNT + 1);
    localparam int RW = $clog2(REP_CNT + 1);
    localparam int IW = $clog2(N_BTN);

    logic [N_BTN-1:0] pend;
    logic [N_BTN-1:0] drop;
    logic [N_BTN-1:0] arb_grant;
    logic [N_BTN-1:0] take;
    logic [1:0]       pend_kind [N_BTN];
    logic [IW-1:0]    grant_idx;
    logic             load;

    assign load = !evt.evt_valid || evt.evt_ready;
    assign take = arb_grant & {N_BTN{load}};

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_state_t    state;
        logic [HW-1:0] hold_cnt;
        logic [RW-1:0] rep_cnt;
        logic          pend_r;
        logic [1:0]    kind_r;
        logic          raise_l;
        logic [1:0]    kind_l;
        logic          hold_hit;
        logic          rep_hit;

        // Hits fire on the cycle whose increment would reach the target count.
        assign hold_hit = (hold_cnt == HW'(LONG_CNT - 1));
        assign rep_hit  = (rep_cnt == RW'(REP_CNT - 1));

        always_comb begin
            raise_l = 1'b0;
            kind_l  = EVT_PRESS;
            case (state)
                ST_IDLE: raise_l = press_pulse[i];
                ST_HELD: begin
                    raise_l = btn_stable[i] && hold_hit;
                    kind_l  = EVT_LONG;
                end
                ST_LONG: begin
                    raise_l = btn_stable[i] && rep_hit;
                    kind_l  = EVT_REPEAT;
                end
                default: raise_l = 1'b0;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state    <= ST_IDLE;
                hold_cnt <= '0;
                rep_cnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (press_pulse[i]) begin
                            state    <= ST_HELD;
                            hold_cnt <= '0;
                        end
                    end
                    ST_HELD: begin
                        if (!btn_stable[i]) begin
                            state <= ST_IDLE;
                        end else begin
                            if (hold_cnt != HW'(LONG_CNT)) begin
                                hold_cnt <= hold_cnt + HW'(1);
                            end
                            if (hold_hit) begin
                                state   <= ST_LONG;
                                rep_cnt <= '0;
                            end
                        end
                    end
                    ST_LONG: begin
                        if (!btn_stable[i]) begin
                            state <= ST_IDLE;
                        end else if (rep_hit) begin
                            rep_cnt <= '0;
                        end else if (rep_cnt != RW'(REP_CNT)) begin
                            rep_cnt <= rep_cnt + RW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end

        // A stored entry is only replaced when it is leaving through the grant this cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pend_r <= 1'b0;
                kind_r <= EVT_PRESS;
            end else if (raise_l && (!pend_r || take[i])) begin
                pend_r <= 1'b1;
                kind_r <= kind_l;
            end else if (take[i]) begin
                pend_r <= 1'b0;
            end
        end

        assign drop[i]      = raise_l && pend_r && !take[i];
        assign pend[i]      = pend_r;
        assign pend_kind[i] = kind_r;
    end

    rr_arbiter #(
        .N (N_BTN)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (pend),
        .advance   (load),
        .grant     (arb_grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt.evt_valid  <= 1'b0;
            evt.evt_btn    <= '0;
            evt.evt_kind   <= EVT_PRESS;
            evt.drop_pulse <= 1'b0;
        end else begin
            evt.drop_pulse <= |drop;
            if (load) begin
                evt.evt_valid <= |pend;
                if (|pend) begin
                    evt.evt_btn  <= grant_idx;
                    evt.evt_kind <= pend_kind[grant_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb/tb_btn_event_arbiter.sv - directed bench for btn_event_arbiter (1 ms = 1 cycle)
module tb_btn_event_arbiter;
    import btn_pkg::*;

    typedef struct {
        int c;
        int b;
        int k;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] press = '0;
    logic [3:0] stable = '0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         drop_cnt = 0;
    int         drop_cyc = -1;
    int         t0;
    ev_t        q[$];

    btn_event_arbiter_if #(.N_BTN(4)) evt_if ();

    btn_event_arbiter #(
        .N_BTN     (4),
        .CLK_HZ    (1000),
        .LONG_MS   (10),
        .REPEAT_MS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .press_pulse (press),
        .btn_stable  (stable),
        .evt         (evt_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (evt_if.evt_valid && evt_if.evt_ready) begin
            e.c = cyc;
            e.b = int'(evt_if.evt_btn);
            e.k = int'(evt_if.evt_kind);
            q.push_back(e);
        end
        if (evt_if.drop_pulse) begin
            drop_cnt++;
            drop_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input int idx, input int c, input int b, input int k);
        if (idx >= q.size()) begin
            chk({tag, "_present"}, q.size(), idx + 1);
        end else begin
            chk({tag, "_cyc"}, q[idx].c, c);
            chk({tag, "_btn"}, q[idx].b, b);
            chk({tag, "_kind"}, q[idx].k, k);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle press on every button in mask, level held two cycles.
    task automatic tap(input logic [3:0] mask, output int tstart);
        q.delete();
        tstart = cyc;
        press  = mask;
        stable = mask;
        step(1);
        press = '0;
        step(1);
        stable = '0;
        step(6);
    endtask

    initial begin
        evt_if.evt_ready = 1'b1;
        step(3);
        chk("rst_valid", int'(evt_if.evt_valid), 0);
        chk("rst_btn", int'(evt_if.evt_btn), 0);
        chk("rst_kind", int'(evt_if.evt_kind), 0);
        chk("rst_drop", int'(evt_if.drop_pulse), 0);
        rst = 1'b0;
        step(2);

        // short press
        q.delete();
        t0 = cyc;
        press[0] = 1'b1;
        stable[0] = 1'b1;
        step(1);
        press = '0;
        step(3);
        stable[0] = 1'b0;
        step(12);
        chk("t1_count", q.size(), 1);
        chk_ev("t1_e0", 0, t0 + 2, 0, int'(EVT_PRESS));

        // long hold with repeats
        q.delete();
        t0 = cyc;
        press[1] = 1'b1;
        stable[1] = 1'b1;
        step(1);
        press = '0;
        step(19);
        stable[1] = 1'b0;
        step(20);
        chk("t2_count", q.size(), 4);
        chk_ev("t2_press", 0, t0 + 2, 1, int'(EVT_PRESS));
        chk_ev("t2_long", 1, t0 + 12, 1, int'(EVT_LONG));
        chk_ev("t2_rep0", 2, t0 + 16, 1, int'(EVT_REPEAT));
        chk_ev("t2_rep1", 3, t0 + 20, 1, int'(EVT_REPEAT));

        // round-robin order from a fresh pointer
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        tap(4'b0101, t0);
        chk("t3a_count", q.size(), 2);
        chk_ev("t3a_e0", 0, t0 + 2, 0, int'(EVT_PRESS));
        chk_ev("t3a_e1", 1, t0 + 3, 2, int'(EVT_PRESS));
        tap(4'b0101, t0);
        chk("t3b_count", q.size(), 2);
        chk_ev("t3b_e0", 0, t0 + 2, 0, int'(EVT_PRESS));
        chk_ev("t3b_e1", 1, t0 + 3, 2, int'(EVT_PRESS));
        tap(4'b0010, t0);
        chk_ev("t3c_e0", 0, t0 + 2, 1, int'(EVT_PRESS));
        tap(4'b0110, t0);
        chk("t3d_count", q.size(), 2);
        chk_ev("t3d_e0", 0, t0 + 2, 2, int'(EVT_PRESS));
        chk_ev("t3d_e1", 1, t0 + 3, 1, int'(EVT_PRESS));

        // backpressure, full pending slot, dropped repeat
        q.delete();
        drop_cnt = 0;
        evt_if.evt_ready = 1'b0;
        t0 = cyc;
        press[3] = 1'b1;
        stable[3] = 1'b1;
        step(1);
        press = '0;
        step(2);
        chk("t4_valid_a", int'(evt_if.evt_valid), 1);
        chk("t4_btn_a", int'(evt_if.evt_btn), 3);
        chk("t4_kind_a", int'(evt_if.evt_kind), int'(EVT_PRESS));
        step(9);
        chk("t4_valid_b", int'(evt_if.evt_valid), 1);
        chk("t4_btn_b", int'(evt_if.evt_btn), 3);
        chk("t4_kind_b", int'(evt_if.evt_kind), int'(EVT_PRESS));
        step(3);
        stable[3] = 1'b0;
        step(5);
        chk("t4_drop_cnt", drop_cnt, 1);
        chk("t4_drop_cyc", drop_cyc, t0 + 15);
        chk("t4_none_yet", q.size(), 0);
        evt_if.evt_ready = 1'b1;
        step(6);
        chk("t4_count", q.size(), 2);
        chk_ev("t4_press", 0, t0 + 20, 3, int'(EVT_PRESS));
        chk_ev("t4_long", 1, t0 + 21, 3, int'(EVT_LONG));

        // reset while an event is held and another pending
        q.delete();
        drop_cnt = 0;
        evt_if.evt_ready = 1'b0;
        t0 = cyc;
        press[1] = 1'b1;
        stable[1] = 1'b1;
        step(1);
        press = '0;
        step(11);
        chk("t5_pre_valid", int'(evt_if.evt_valid), 1);
        rst = 1'b1;
        #2;
        chk("t5_async_valid", int'(evt_if.evt_valid), 0);
        step(1);
        chk("t5_valid", int'(evt_if.evt_valid), 0);
        chk("t5_btn", int'(evt_if.evt_btn), 0);
        chk("t5_kind", int'(evt_if.evt_kind), 0);
        rst = 1'b0;
        evt_if.evt_ready = 1'b1;
        step(30);
        chk("t5_no_events", q.size(), 0);
        chk("t5_no_drops", drop_cnt, 0);
        stable = '0;
        step(2);

        // release exactly on the LONG boundary
        q.delete();
        t0 = cyc;
        press[2] = 1'b1;
        stable[2] = 1'b1;
        step(1);
        press = '0;
        step(9);
        stable[2] = 1'b0;
        step(1);
        stable[2] = 1'b1;
        step(20);
        stable = '0;
        step(3);
        chk("t6_count", q.size(), 1);
        chk_ev("t6_press", 0, t0 + 2, 2, int'(EVT_PRESS));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
